// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter8_if : request/grant bundle between requester bank and arbiter |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  // Requester side: drives requests, observes the grant.
  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter8 : eight-way round-robin arbiter with per-grant hold limit    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  rr_arbiter8_if.slave     bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic       c_limit_en  = (MAX_HOLD != 0);
  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

  state_t     r_state,     w_state_nxt;
  logic [7:0] r_gnt,       w_gnt_nxt;
  logic [2:0] r_gnt_idx,   w_gnt_idx_nxt;
  logic       r_gnt_valid, w_gnt_valid_nxt;
  logic       r_timeout,   w_timeout_nxt;
  logic [2:0] r_ptr,       w_ptr_nxt;
  logic [7:0] r_hold_cnt,  w_hold_cnt_nxt;

  logic [7:0]  w_rot;
  logic [7:0]  w_rot_low;
  logic [15:0] w_oh2;
  logic [7:0]  w_win_oh;
  logic [2:0]  w_win_idx;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign w_rot     = 8'({bus.req, bus.req} >> r_ptr);
  assign w_rot_low = w_rot & (~w_rot + 8'd1);
  assign w_oh2     = {8'b0, w_rot_low} << r_ptr;
  assign w_win_oh  = w_oh2[7:0] | w_oh2[15:8];

  // One-hot to binary: index bit b is the OR of grant lines whose index has bit b set.
  for (genvar b = 0; b < 3; b++) begin : g_enc
    logic [7:0] w_mask;
    for (genvar k = 0; k < 8; k++) begin : g_mask
      assign w_mask[k] = 1'(k >> b);
    end
    assign w_win_idx[b] = |(w_win_oh & w_mask);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    w_ptr_nxt       = r_ptr;
    w_hold_cnt_nxt  = r_hold_cnt;

    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_gnt_nxt       = w_win_oh;
          w_gnt_idx_nxt   = w_win_idx;
          w_gnt_valid_nxt = 1'b1;
          w_ptr_nxt       = w_win_idx + 3'd1;
          w_hold_cnt_nxt  = 8'd0;
          w_state_nxt     = S_GRANT;
        end
      end
      S_GRANT: begin
        // Owner release wins over limit expiry at the same edge.
        if (!bus.req[r_gnt_idx]) begin
          w_gnt_nxt       = 8'd0;
          w_gnt_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if (c_limit_en && (r_hold_cnt == c_hold_last)) begin
          w_gnt_nxt       = 8'd0;
          w_gnt_valid_nxt = 1'b0;
          w_timeout_nxt   = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_hold_cnt_nxt  = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_gnt_nxt       = 8'd0;
        w_gnt_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= 8'd0;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= 3'd0;
      r_hold_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_arbiter8 : three arbiters (hold limit 16, 4, off) vs. a model      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rr_arbiter8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter8_if if0 ();
  rr_arbiter8_if if1 ();
  rr_arbiter8_if if2 ();

  rr_arbiter8 #(.MAX_HOLD(16)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  rr_arbiter8 #(.MAX_HOLD(4))  u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  rr_arbiter8 #(.MAX_HOLD(0))  u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  logic [7:0] req_a [3];
  logic [7:0] gnt_a [3];
  logic [2:0] idx_a [3];
  logic       val_a [3];
  logic       to_a  [3];

  assign if0.req = req_a[0];
  assign if1.req = req_a[1];
  assign if2.req = req_a[2];
  assign gnt_a[0] = if0.gnt; assign idx_a[0] = if0.gnt_idx; assign val_a[0] = if0.gnt_valid; assign to_a[0] = if0.timeout;
  assign gnt_a[1] = if1.gnt; assign idx_a[1] = if1.gnt_idx; assign val_a[1] = if1.gnt_valid; assign to_a[1] = if1.timeout;
  assign gnt_a[2] = if2.gnt; assign idx_a[2] = if2.gnt_idx; assign val_a[2] = if2.gnt_valid; assign to_a[2] = if2.timeout;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: owner is -1 when nobody holds; held counts visible grant cycles.
  int lim     [3] = '{16, 4, 0};
  int m_owner [3];
  int m_last  [3];
  int m_start [3];
  int m_held  [3];
  bit m_to    [3];

  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (rst) begin
        m_owner[n] = -1; m_last[n] = 0; m_start[n] = 0; m_held[n] = 0; m_to[n] = 0;
      end else if (m_owner[n] < 0) begin
        m_to[n] = 0;
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_start[n] + k) % 8;
          if (m_owner[n] < 0 && req_a[n][c]) begin
            m_owner[n] = c; m_last[n] = c; m_start[n] = (c + 1) % 8; m_held[n] = 1;
          end
        end
      end else if (!req_a[n][m_owner[n]]) begin
        m_owner[n] = -1; m_to[n] = 0;
      end else if (lim[n] != 0 && m_held[n] == lim[n]) begin
        m_owner[n] = -1; m_to[n] = 1;
      end else begin
        m_held[n]++; m_to[n] = 0;
      end
    end
    #1;
    for (int n = 0; n < 3; n++) begin
      check($sformatf("model_gnt[%0d]", n), gnt_a[n], (m_owner[n] < 0) ? 0 : (1 << m_owner[n]));
      check($sformatf("model_idx[%0d]", n), idx_a[n], m_last[n]);
      check($sformatf("model_valid[%0d]", n), val_a[n], (m_owner[n] >= 0) ? 1 : 0);
      check($sformatf("model_timeout[%0d]", n), to_a[n], m_to[n]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    req_a[0] = 8'hFF; req_a[1] = 8'h00; req_a[2] = 8'h00;
    rst = 1'b1;
    tick(2);
    check("rst_gnt", gnt_a[0], 8'h00);
    check("rst_idx", idx_a[0], 0);
    check("rst_valid", val_a[0], 0);
    check("rst_timeout", to_a[0], 0);
    rst = 1'b0;
    tick(1);
    check("first_gnt", gnt_a[0], 8'h01);
    check("first_idx", idx_a[0], 0);

    // Single request, then saturation grants next in line
    req_a[0] = 8'h00; tick(2);
    req_a[0] = 8'h04; tick(1);
    check("single_gnt", gnt_a[0], 8'h04);
    check("single_idx", idx_a[0], 2);
    req_a[0] = 8'h00; tick(1);
    check("single_release", gnt_a[0], 8'h00);
    check("idle_holds_idx", idx_a[0], 2);
    req_a[0] = 8'hFF; tick(1);
    check("after2_idx", idx_a[0], 3);

    // Wrap-around
    req_a[0] = 8'h00; tick(1);
    req_a[0] = 8'h20; tick(1);
    check("wrap_g5", idx_a[0], 5);
    req_a[0] = 8'h00; tick(1);
    req_a[0] = 8'h21; tick(1);
    check("wrap_gnt", gnt_a[0], 8'h01);
    check("wrap_idx", idx_a[0], 0);
    req_a[0] = 8'h00; tick(1);
    req_a[0] = 8'hFF; tick(1);
    check("wrap_ptr1", idx_a[0], 1);
    req_a[0] = 8'h00;

    // Saturation rotation with a hold limit of 4
    req_a[1] = 8'hFF;
    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 4; c++) begin
        tick(1);
        check("rot_idx", idx_a[1], o % 8);
        check("rot_gnt", gnt_a[1], 1 << (o % 8));
      end
      tick(1);
      check("rot_timeout", to_a[1], 1);
      check("rot_gap", gnt_a[1], 0);
    end
    req_a[1] = 8'h00; tick(2);

    // Sole requester is forced off and regranted
    req_a[1] = 8'h08;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      check("sole_idx", idx_a[1], 3);
      check("sole_valid", val_a[1], 1);
    end
    tick(1);
    check("sole_timeout", to_a[1], 1);
    check("sole_gap", gnt_a[1], 0);
    tick(1);
    check("sole_regrant", gnt_a[1], 8'h08);
    req_a[1] = 8'h00;

    // No limit: held indefinitely
    req_a[2] = 8'h08; tick(1);
    for (int c = 0; c < 300; c++) begin
      check("nolimit_gnt", gnt_a[2], 8'h08);
      check("nolimit_to", to_a[2], 0);
      tick(1);
    end
    req_a[2] = 8'h00;

    // Reset in the middle of a grant
    tick(2);
    req_a[0] = 8'h40; tick(3);
    check("mid_owner6", idx_a[0], 6);
    rst = 1'b1; tick(1);
    check("midrst_gnt", gnt_a[0], 0);
    check("midrst_idx", idx_a[0], 0);
    check("midrst_valid", val_a[0], 0);
    rst = 1'b0; req_a[0] = 8'h41; tick(1);
    check("midrst_regrant", gnt_a[0], 8'h01);

    // Randomized traffic, occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 3; n++)
        if ($urandom_range(0, 3) == 0) req_a[n] = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
